// File: rtl/interval_timer.sv
// Programmable interval timer: runtime-loaded period, one-shot or periodic
// mode, tick-enable prescaling, stop/retrigger, stretched done pulse, expiry count.
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | timer not running, counter parked at 0
// RUN   | counting down on tick_en, busy asserted
module interval_timer #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned EXP_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_en,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [CNT_W-1:0] load_value,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining,
  output logic [EXP_W-1:0] exp_count,
  output logic             load_err
);

  localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic [PW-1:0]    pulse_q, pulse_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             load_err_q, load_err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      period_q    <= '0;
      mode_q      <= 1'b0;
      pulse_q     <= '0;
      exp_q       <= '0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      period_q    <= period_d;
      mode_q      <= mode_d;
      pulse_q     <= pulse_d;
      exp_q       <= exp_d;
      load_err_q  <= load_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    period_d    = period_q;
    mode_d      = mode_q;
    exp_d       = exp_q;
    load_err_d  = 1'b0;
    // The pulse stretcher runs on clk alone so done width is independent of tick_en.
    pulse_d     = (pulse_q != '0) ? pulse_q - PW'(1) : '0;

    if (stop) begin
      state_d     = IDLE;
      remaining_d = '0;
      pulse_d     = '0;
    end else if (start) begin
      if (load_value != '0) begin
        period_d    = load_value;
        mode_d      = periodic;
        remaining_d = load_value - CNT_W'(1);
        state_d     = RUN;
      end else begin
        load_err_d  = 1'b1;
      end
    end else if (state_q == RUN && tick_en) begin
      if (remaining_q != '0) begin
        remaining_d = remaining_q - CNT_W'(1);
      end else begin
        exp_d   = exp_q + EXP_W'(1);
        pulse_d = PW'(PULSE_CYCLES);
        if (mode_q) begin
          remaining_d = period_q - CNT_W'(1);
        end else begin
          state_d     = IDLE;
          remaining_d = '0;
        end
      end
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (pulse_q != '0);
  assign remaining = remaining_q;
  assign exp_count = exp_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: directed scenarios plus random
// stimulus, compared every cycle against a time-based reference model.
module tb_interval_timer;
  localparam int CNT_W = 32;
  localparam int PULSE = 2;
  localparam int EXP_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             tick_en = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             periodic = 1'b0;
  logic [CNT_W-1:0] load_value = '0;
  logic             busy, done, load_err;
  logic [CNT_W-1:0] remaining;
  logic [EXP_W-1:0] exp_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: ticks left before expiry, and done as an absolute end time.
  bit               m_run, m_mode, m_err;
  logic [CNT_W-1:0] m_left, m_period;
  int               m_exp;
  longint           cyc = 0;
  longint           m_done_end = 0;

  always #5 clk = ~clk;

  interval_timer #(.CNT_W(CNT_W), .PULSE_CYCLES(PULSE), .EXP_W(EXP_W)) dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .start(start), .stop(stop),
    .periodic(periodic), .load_value(load_value), .busy(busy), .done(done),
    .remaining(remaining), .exp_count(exp_count), .load_err(load_err)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    cyc++;
    m_err = 1'b0;
    if (reset) begin
      m_run = 0; m_mode = 0; m_left = '0; m_period = '0; m_exp = 0; m_done_end = cyc;
    end else if (stop) begin
      m_run = 0; m_left = '0; m_done_end = cyc;
    end else if (start) begin
      if (load_value == 0) m_err = 1'b1;
      else begin
        m_run = 1; m_mode = periodic; m_period = load_value; m_left = load_value - 1;
      end
    end else if (m_run && tick_en) begin
      if (m_left > 0) m_left = m_left - 1;
      else begin
        m_exp = (m_exp + 1) % (1 << EXP_W);
        m_done_end = cyc + PULSE;
        if (m_mode) m_left = m_period - 1;
        else m_run = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_val("busy", busy, m_run);
    check_val("done", done, cyc < m_done_end);
    check_val("remaining", remaining, m_left);
    check_val("exp_count", exp_count, m_exp);
    check_val("load_err", load_err, m_err);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic kick(input logic [CNT_W-1:0] lv, input logic per);
    start = 1'b1; load_value = lv; periodic = per;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    tick_en = 1'b1;

    // one-shot, 10 ticks
    kick(10, 0);
    steps(9);
    check_val("os_busy_last", busy, 1);
    step();
    check_val("os_done_rise", done, 1);
    steps(4);
    check_val("os_exp", exp_count, 1);
    check_val("os_idle", busy, 0);

    // periodic, 4 ticks, five expiries in 20 cycles then stop
    kick(4, 1);
    steps(20);
    check_val("per_exp", exp_count, 6);
    stop = 1'b1; step(); stop = 1'b0;
    check_val("per_stop_busy", busy, 0);
    check_val("per_stop_done", done, 0);

    // prescaled: one tick in three
    kick(3, 0);
    for (int i = 0; i < 15; i++) begin
      tick_en = (i % 3 == 2);
      step();
    end
    tick_en = 1'b1;

    // retrigger at remaining=2
    kick(8, 0);
    steps(5);
    check_val("rt_pre", remaining, 2);
    kick(5, 0);
    check_val("rt_post", remaining, 4);
    steps(8);
    // start and stop together
    kick(6, 0);
    start = 1'b1; stop = 1'b1; load_value = 9; step();
    start = 1'b0; stop = 1'b0;
    check_val("ss_idle", busy, 0);

    // zero load value, in RUN and in IDLE
    kick(6, 0);
    steps(2);
    kick(0, 1);
    check_val("z_err", load_err, 1);
    check_val("z_busy", busy, 1);
    steps(6);
    kick(0, 0);
    steps(2);

    // periodic period 1: done stays high, exp_count wraps
    kick(1, 1);
    steps(300);
    stop = 1'b1; step(); stop = 1'b0;

    // reset mid-run and during a done pulse
    kick(20, 0);
    steps(5);
    reset = 1'b1; step(); reset = 1'b0;
    check_val("rst_busy", busy, 0);
    kick(2, 0);
    steps(2);
    reset = 1'b1; step(); reset = 1'b0;
    check_val("rst_done", done, 0);
    kick(3, 0);
    steps(5);

    // maximum period
    kick('1, 0);
    steps(3);
    stop = 1'b1; step(); stop = 1'b0;

    // random phase
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 299) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      start    = ($urandom_range(0, 11) == 0);
      periodic = $urandom_range(0, 1);
      tick_en  = ($urandom_range(0, 2) != 0);
      load_value = ($urandom_range(0, 7) == 0) ? '0 : CNT_W'($urandom_range(1, 12));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
- Parametrised programmable interval timer; successor to the fixed-count one-shot second timer used by the game/sequence control logic.
- Supports a runtime-loaded period, one-shot or periodic mode, tick-enable prescaling, stop/retrigger, a configurable done-pulse width, and an expiry counter.
- Sits between the top-level FSMs and the board clock; consumers watch `done` or `busy`.

Parameters:
- CNT_W, 32: width of the period/remaining counter.
- PULSE_CYCLES, 2: `done` high time per expiry in clk cycles; must be ≥1.
- EXP_W, 8: width of the wrapping expiry counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clock clk
- tick_en  in  1  count-enable (prescaler strobe); counter moves only when 1
- start  in  1  level sampled each edge; accepts `load_value` and (re)starts timing
- stop  in  1  abort timing, return to IDLE
- periodic  in  1  mode sampled with `start`: 0 = one-shot, 1 = auto-reload
- load_value  in  CNT_W  period in ticks; 0 is illegal
- busy  out  1  high in RUN
- done  out  1  expiry pulse, PULSE_CYCLES wide
- remaining  out  CNT_W  current down-counter value
- exp_count  out  EXP_W  number of expiries since reset, wraps
- load_err  out  1  one-cycle flag: start seen with load_value==0

Behaviour:
- Reset values (priority over everything):
  - State IDLE; busy=0, done=0, remaining=0, exp_count=0, load_err=0.
  - Latched period=0, latched mode=0, pulse counter=0.
- States:
  - IDLE: timer not running.
  - RUN: counting down. busy=1 exactly in RUN.
- Priority each edge: reset > stop > start > counting.
- stop:
  - Next state IDLE; busy=0, done=0, pulse counter cleared, remaining=0.
  - If stop and start are both high, stop wins.
- start with load_value≠0 (from IDLE or RUN):
  - Latch period=load_value and mode=periodic.
  - Set remaining=load_value-1, next state RUN.
  - A start in RUN is a retrigger. It does not clear a `done` pulse already in progress.
- start with load_value==0:
  - Ignored; state unchanged.
  - load_err=1 for that one cycle only.
- RUN, tick_en=1, no start/stop:
  - If remaining≠0: decrement remaining.
  - If remaining==0: expiry.
- RUN, tick_en=0: hold all state.
- Expiry:
  - exp_count increments modulo 2^EXP_W.
  - Pulse counter loads PULSE_CYCLES; done=1 from the next cycle for exactly PULSE_CYCLES cycles.
  - One-shot mode: next state IDLE, remaining stays 0.
  - Periodic mode: remaining=period-1, stays in RUN.
- Latency: with tick_en tied high and start accepted at edge k, expiry occurs at edge k+N, where N = load_value. done is high for cycles k+N … k+N+PULSE_CYCLES-1. N=1 gives expiry on the very next edge.
- Pulse counting:
  - Decrements every clk, independent of tick_en.
  - done = (pulse counter ≠ 0).
  - An expiry during an active pulse reloads the pulse counter. If period < PULSE_CYCLES, done stays continuously high.
- Restart after one-shot:
  - A start may be accepted while done is still high from the previous expiry.
  - The pulse continues to completion; the new run proceeds in parallel.
- Arithmetic:
  - remaining and period are unsigned CNT_W. load_value=2^CNT_W-1 is legal.
  - No decrement below 0 occurs.
- tick_en is ignored in IDLE.
- Outputs are registered; no combinational input-to-output paths except none (load_err is registered too).

Test Plan:
- Reset, then start=1 for one cycle with load_value=10, periodic=0, tick_en=1 → busy high 10 cycles; done high exactly 2 cycles starting 10 cycles after start; exp_count=1; back to IDLE.
- Periodic, load_value=4, tick_en=1, run 20 cycles → done rises every 4 cycles (5 expiries); exp_count=5; busy stays 1; then stop → busy=0, done=0 next cycle.
- tick_en asserted 1 cycle in 3, load_value=3, one-shot → expiry after the 3rd tick past start (≈9 clk); remaining holds between ticks.
- Retrigger: load_value=8, at remaining=2 assert start with load_value=5 → remaining=4 next cycle; expiry 5 ticks later; exp_count=1. Separately, start and stop in the same cycle → IDLE.
- load_value=0 with start → load_err pulses 1 cycle; state and busy unchanged. Periodic load_value=1 with PULSE_CYCLES=2 → done continuously high; exp_count increments every cycle and wraps 255→0.
- Reset asserted mid-RUN and during a done pulse → all outputs 0 on the next edge; subsequent start behaves as from cold.
